// File: rtl/jt6295_chseq.sv
// jt6295_chseq: four-channel phrase sequencer for the JT6295 ADPCM core.
// Holds per-channel playback state, services one channel per cen4 slot in
// round-robin order, fetches the ROM byte holding the next nibble and emits
// one nibble (or a mute marker for idle channels) to the decoder.
//
// state  | meaning
// IDLE   | waiting for cen4 or a pending (overrun) slot
// FETCH  | ROM read for the serviced slot; first cycle is address settle
// EMIT   | one-clk strobe of a playing channel's nibble, then channel update
// MUTE   | one-clk strobe for an idle slot, dout forced to 0
module jt6295_chseq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen4,
  input  logic [3:0]  start,
  input  logic [3:0]  stop,
  input  logic [17:0] start_addr,
  input  logic [17:0] stop_addr,
  input  logic [3:0]  att,
  output logic [3:0]  busy,
  output logic [3:0]  ack,
  output logic        zero,
  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic [3:0]  dout,
  output logic [1:0]  dout_ch,
  output logic [3:0]  dout_att,
  output logic        dout_first,
  output logic        dout_mute,
  output logic        dout_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_MUTE  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  slot;
  logic [1:0]  cur;
  logic        pending;
  logic [1:0]  pend_slot;
  logic        fetch_first;
  logic [17:0] fetch_addr;
  logic [7:0]  byte_r;

  logic [17:0] ch_addr [4];
  logic [17:0] ch_end  [4];
  logic [3:0]  ch_att  [4];
  logic [3:0]  ch_nib;
  logic [3:0]  ch_first;

  logic        take;
  logic [1:0]  svc_slot;

  // Next-state: pick the slot to service (pending first) and route by busy
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    svc_slot = slot;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          take     = 1'b1;
          svc_slot = pend_slot;
        end else if (cen4) begin
          take     = 1'b1;
          svc_slot = slot;
        end
        if (take) state_nx = busy[svc_slot] ? ST_FETCH : ST_MUTE;
      end
      ST_FETCH: begin
        if (!fetch_first && rom_ok) state_nx = ST_EMIT;
      end
      ST_EMIT:  state_nx = ST_IDLE;
      ST_MUTE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output decode; everything is zero unless the FSM is fetching or emitting
  always_comb begin
    rom_cs     = (state == ST_FETCH);
    rom_addr   = rom_cs ? fetch_addr : 18'd0;
    dout_valid = (state == ST_EMIT) || (state == ST_MUTE);
    dout_mute  = (state == ST_MUTE);
    dout_ch    = dout_valid ? cur : 2'd0;
    dout_att   = 4'd0;
    dout_first = 1'b0;
    dout       = 4'd0;
    if (state == ST_EMIT) begin
      dout_att   = ch_att[cur];
      dout_first = ch_first[cur];
      dout       = ch_nib[cur] ? byte_r[3:0] : byte_r[7:4];
    end
  end

  // FSM register, serviced slot, latched fetch address and ROM byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur         <= 2'd0;
      fetch_first <= 1'b0;
      fetch_addr  <= 18'd0;
      byte_r      <= 8'd0;
    end else begin
      state       <= state_nx;
      fetch_first <= take && busy[svc_slot];
      if (take) begin
        cur        <= svc_slot;
        // Latched so rom_addr cannot move even if the channel is reloaded mid-fetch
        fetch_addr <= ch_addr[svc_slot];
      end
      if (state == ST_FETCH && !fetch_first && rom_ok) byte_r <= rom_data;
    end
  end

  // Slot counter, wrap pulse and the one-deep overrun slot
  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= 2'd0;
      zero      <= 1'b0;
      pending   <= 1'b0;
      pend_slot <= 2'd0;
    end else begin
      if (cen4) slot <= slot + 2'd1;
      zero <= cen4 && (slot == 2'd3);
      // A cen4 not consumed directly by IDLE is parked; a newer one replaces it
      if (cen4 && !(state == ST_IDLE && !pending)) begin
        pending   <= 1'b1;
        pend_slot <= slot;
      end else if (state == ST_IDLE && pending) begin
        pending <= 1'b0;
      end
    end
  end

  // Per-channel playback registers: start load wins over stop and EMIT update
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 4'd0;
      ack      <= 4'd0;
      ch_nib   <= 4'd0;
      ch_first <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        ch_addr[i] <= 18'd0;
        ch_end[i]  <= 18'd0;
        ch_att[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        ack[i] <= start[i] && !ack[i];
        if (start[i] && !ack[i] && !busy[i]) begin
          ch_addr[i]  <= start_addr;
          ch_end[i]   <= stop_addr;
          ch_att[i]   <= att;
          ch_nib[i]   <= 1'b0;
          ch_first[i] <= 1'b1;
          busy[i]     <= 1'b1;
        end else begin
          if (cen4 && stop[i]) busy[i] <= 1'b0;
          if (state == ST_EMIT && cur == 2'(i)) begin
            ch_first[i] <= 1'b0;
            ch_nib[i]   <= ~ch_nib[i];
            if (ch_nib[i]) begin
              if (ch_addr[i] == ch_end[i]) busy[i] <= 1'b0;
              else ch_addr[i] <= ch_addr[i] + 18'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jt6295_chseq.sv
// Bench for jt6295_chseq: the reference model keeps each channel's phrase as
// a queue of (nibble, byte address) built from the start/stop range; each
// cen4 pops the serviced channel's next nibble (or predicts a mute slot) into
// a scoreboard that an independent monitor checks against dout_*/rom_*.
module tb_jt6295_chseq;

  logic        clk, rst, cen4;
  logic [3:0]  start, stop, att;
  logic [17:0] start_addr, stop_addr;
  logic [3:0]  busy, ack;
  logic        zero;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic [3:0]  dout;
  logic [1:0]  dout_ch;
  logic [3:0]  dout_att;
  logic        dout_first, dout_mute, dout_valid;

  jt6295_chseq dut (
    .clk(clk), .rst(rst), .cen4(cen4), .start(start), .stop(stop),
    .start_addr(start_addr), .stop_addr(stop_addr), .att(att),
    .busy(busy), .ack(ack), .zero(zero), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok), .dout(dout), .dout_ch(dout_ch),
    .dout_att(dout_att), .dout_first(dout_first), .dout_mute(dout_mute),
    .dout_valid(dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic       mute;
    logic [3:0] nib;
    logic [3:0] att;
    logic       first;
  } exp_t;

  typedef struct packed {
    logic [3:0]  nib;
    logic [17:0] addr;
  } ph_t;

  exp_t        exp_q[$];
  logic [17:0] addr_q[$];
  ph_t         ph_q[4][$];
  logic [3:0]  m_att[4];
  logic        m_first[4];

  int total = 0, bad = 0;
  int rom_lat = 0, cs_cnt = 0, cen_count = 0, cs_cycles = 0;

  function automatic logic [7:0] rom_fn(input logic [17:0] a);
    if (a == 18'h00100) return 8'hA5;
    if (a == 18'h00101) return 8'h3C;
    return a[7:0] ^ {a[15:12], a[17:14]} ^ 8'h5A;
  endfunction

  // ROM model: data follows the address, rom_ok after rom_lat cycles of rom_cs
  always @(posedge clk) cs_cnt <= rom_cs ? cs_cnt + 1 : 0;
  assign rom_ok   = rom_cs && (cs_cnt >= rom_lat);
  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_busy_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (ph_q[i].size() != 0);
    return m;
  endfunction

  function automatic void m_start(input logic [3:0] mask, input logic [17:0] sa,
                                  input logic [17:0] ea, input logic [3:0] a);
    int n;
    logic [17:0] ba;
    logic [7:0]  b;
    n = int'(18'(ea - sa)) + 1;
    for (int i = 0; i < 4; i++) begin
      if (mask[i] && ph_q[i].size() == 0) begin
        for (int k = 0; k < n; k++) begin
          ba = 18'(sa + 18'(k));
          b  = rom_fn(ba);
          ph_q[i].push_back({b[7:4], ba});
          ph_q[i].push_back({b[3:0], ba});
        end
        m_att[i]   = a;
        m_first[i] = 1'b1;
      end
    end
  endfunction

  function automatic void m_cen(input logic [3:0] stp, input bit serviced);
    int s;
    ph_t p;
    s = cen_count % 4;
    cen_count++;
    if (serviced) begin
      if (ph_q[s].size() == 0) begin
        exp_q.push_back({2'(s), 1'b1, 4'd0, 4'd0, 1'b0});
      end else begin
        p = ph_q[s].pop_front();
        exp_q.push_back({2'(s), 1'b0, p.nib, m_att[s], m_first[s]});
        addr_q.push_back(p.addr);
        m_first[s] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) if (stp[i]) ph_q[i].delete();
  endfunction

  // Monitor: pops the scoreboard on every dout_valid and every new fetch
  initial begin
    exp_t        e;
    logic        cs_prev;
    logic [17:0] ea;
    cs_prev = 1'b0;
    ea      = 18'd0;
    forever begin
      @(negedge clk);
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dout actual ch=%0d mute=%0d required=none", dout_ch, dout_mute);
        end else begin
          e = exp_q.pop_front();
          check("dout_ch", dout_ch, e.ch);
          check("dout_mute", dout_mute, e.mute);
          check("dout", dout, e.nib);
          check("dout_att", dout_att, e.att);
          check("dout_first", dout_first, e.first);
        end
      end
      if (rom_cs) begin
        cs_cycles++;
        if (!cs_prev) begin
          if (addr_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_fetch actual addr=%0h required=none", rom_addr);
          end else begin
            ea = addr_q.pop_front();
            check("rom_addr", rom_addr, ea);
          end
        end else begin
          check("rom_addr_stable", rom_addr, ea);
        end
      end
      cs_prev = rom_cs;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, {busy, ack, zero, rom_cs, rom_addr, dout, dout_ch, dout_att,
                 dout_first, dout_mute, dout_valid}, 0);
  endtask

  task automatic do_start(input logic [3:0] smask, input logic [17:0] sa,
                          input logic [17:0] ea, input logic [3:0] a);
    start = smask; start_addr = sa; stop_addr = ea; att = a;
    tick();
    check("ack", ack, smask);
    m_start(smask, sa, ea, a);
    check("busy_after_start", busy, m_busy_mask());
    start = 4'd0;
    tick();
    check("ack_drop", ack, 4'd0);
  endtask

  // One 8-clk slot: cen4 (+stop), service window, then an optional start
  task automatic slot_iter(input logic [3:0] stp, input logic [3:0] smask,
                           input logic [17:0] sa, input logic [17:0] ea, input logic [3:0] a);
    int s, first_v, nv, nz, exp_lat;
    bit wrap, svc_busy;
    s        = cen_count % 4;
    wrap     = (s == 3);
    svc_busy = (ph_q[s].size() != 0);
    exp_lat  = svc_busy ? ((rom_lat > 1 ? rom_lat : 1) + 2) : 1;
    cen4 = 1'b1; stop = stp;
    m_cen(stp, 1'b1);
    first_v = 0; nv = 0; nz = 0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 1) begin
        cen4 = 1'b0; stop = 4'd0;
        if (stp != 4'd0) check("stop_busy", busy & stp, 4'd0);
      end
      if (dout_valid) begin
        nv++;
        if (first_v == 0) first_v = t;
      end
      if (zero) nz++;
    end
    check("latency", first_v, exp_lat);
    check("valid_count", nv, 1);
    check("zero", nz, wrap ? 1 : 0);
    check("busy", busy, m_busy_mask());
    do_start(smask, sa, ea, a);
  endtask

  // Back-to-back cen4 every 4 clk into a slow fetch: only first and last are serviced
  task automatic burst(input int n);
    for (int j = 0; j < n; j++) begin
      cen4 = 1'b1;
      m_cen(4'd0, (j == 0) || (j == n - 1));
      tick();
      cen4 = 1'b0;
      repeat (3) tick();
    end
    repeat (60) tick();
    check("burst_drain", exp_q.size(), 0);
    check("burst_busy", busy, m_busy_mask());
  endtask

  initial begin
    logic [3:0]  stp, smask, a;
    logic [17:0] sa, ea;
    int s;
    rst = 1'b1; cen4 = 1'b0; start = 4'd0; stop = 4'd0;
    start_addr = 18'd0; stop_addr = 18'd0; att = 4'd0;
    for (int i = 0; i < 4; i++) begin m_att[i] = 4'd0; m_first[i] = 1'b0; end
    repeat (3) tick();
    check_zero_outputs("reset_outputs");
    rst = 1'b0;
    tick();

    repeat (8) slot_iter(4'd0, 4'd0, 18'd0, 18'd0, 4'd0);
    check("rom_cs_idle", cs_cycles, 0);

    slot_iter(4'd0, 4'b0010, 18'h00100, 18'h00101, 4'd3);
    repeat (16) slot_iter(4'd0, 4'd0, 18'd0, 18'd0, 4'd0);

    slot_iter(4'd0, 4'b0100, 18'h02000, 18'h02001, 4'd5);
    slot_iter(4'd0, 4'b0100, 18'h03000, 18'h03005, 4'd9);
    repeat (14) slot_iter(4'd0, 4'd0, 18'd0, 18'd0, 4'd0);

    slot_iter(4'd0, 4'b0001, 18'h00500, 18'h00507, 4'd7);
    repeat (6) slot_iter(4'd0, 4'd0, 18'd0, 18'd0, 4'd0);
    slot_iter(4'b0001, 4'd0, 18'd0, 18'd0, 4'd0);
    repeat (8) slot_iter(4'd0, 4'd0, 18'd0, 18'd0, 4'd0);

    slot_iter(4'd0, 4'b1000, 18'h3FFFF, 18'h00000, 4'd15);
    repeat (16) slot_iter(4'd0, 4'd0, 18'd0, 18'd0, 4'd0);

    for (int r = 0; r < 150; r++) begin
      rom_lat = $urandom_range(0, 2);
      stp   = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      smask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      sa    = 18'($urandom);
      if ($urandom_range(0, 7) == 0) sa = 18'h3FFFF - 18'($urandom_range(0, 1));
      ea    = 18'(sa + 18'($urandom_range(0, 2)));
      a     = 4'($urandom_range(0, 15));
      slot_iter(stp, smask, sa, ea, a);
    end
    rom_lat = 0;
    repeat (24) slot_iter(4'd0, 4'd0, 18'd0, 18'd0, 4'd0);

    slot_iter(4'd0, 4'b1111, 18'h00800, 18'h0080F, 4'd2);
    rom_lat = 10;
    burst(2);
    burst(3);
    burst(2);

    s = cen_count % 4;
    cen4 = 1'b1;
    check("fetch_expected", (ph_q[s].size() != 0) ? 1 : 0, 1);
    m_cen(4'd0, 1'b1);
    tick();
    cen4 = 1'b0;
    repeat (3) tick();
    check("in_fetch", rom_cs, 1'b1);
    rst = 1'b1;
    tick();
    check_zero_outputs("rst_mid_fetch");
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) ph_q[i].delete();
    cen_count = 0;
    rom_lat = 0;
    tick();
    repeat (8) slot_iter(4'd0, 4'd0, 18'd0, 18'd0, 4'd0);

    check("final_exp_q", exp_q.size(), 0);
    check("final_addr_q", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
